// File: rtl/pad_link_tx.sv
// pad_link_tx: frames synchronised left/right/attack plus a 4-bit sequence number
// as start, 7 data bits LSB first, even parity, stop and an idle-high gap on one line.
module pad_link_tx #(
  parameter int CLK_DIV  = 434,
  parameter int GAP_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       left,
  input  logic       right,
  input  logic       attack,
  input  logic       send_en,
  output logic       tx,
  output logic       tx_busy,
  output logic [3:0] seq
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;
  state_t      r_state, w_state;
  logic [2:0]  r_s1, r_s2;
  logic [15:0] r_cnt, w_cnt;
  logic [7:0]  r_sr, w_sr;
  logic [2:0]  r_idx, w_idx;
  logic [3:0]  r_gap, w_gap, r_seq, w_seq;
  logic        r_tx, w_tx, r_busy, w_busy, w_tick;
  assign w_tick = (r_state != IDLE) && (r_cnt == 16'(CLK_DIV - 1));
  // r_sr holds {parity, d6..d0}, so the bit after d6 is simply index 7
  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_idx   = r_idx;
    w_gap   = r_gap;
    w_seq   = r_seq;
    w_tx    = r_tx;
    w_busy  = r_busy;
    w_cnt   = (r_state == IDLE || w_tick) ? 16'd0 : r_cnt + 16'd1;
    case (r_state)
      IDLE: if (send_en) begin
        w_state = START;
        w_tx    = 1'b0;
        w_busy  = 1'b1;
        w_sr    = {^{r_seq, r_s2}, r_seq, r_s2};
      end
      START: if (w_tick) begin
        w_state = DATA;
        w_idx   = 3'd0;
        w_tx    = r_sr[0];
      end
      DATA: if (w_tick) begin
        w_state = (r_idx == 3'd6) ? PARITY : DATA;
        w_idx   = r_idx + 3'd1;
        w_tx    = r_sr[r_idx + 3'd1];
      end
      PARITY: if (w_tick) begin
        w_state = STOP;
        w_tx    = 1'b1;
      end
      STOP: if (w_tick) begin
        w_state = GAP;
        w_gap   = 4'd0;
        w_seq   = r_seq + 4'd1;
      end
      GAP: if (w_tick) begin
        w_gap   = r_gap + 4'd1;
        w_state = (r_gap == 4'(GAP_BITS - 1)) ? IDLE : GAP;
        w_busy  = (r_gap == 4'(GAP_BITS - 1)) ? 1'b0 : r_busy;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s1    <= 3'd0;
      r_s2    <= 3'd0;
      r_cnt   <= 16'd0;
      r_sr    <= 8'd0;
      r_idx   <= 3'd0;
      r_gap   <= 4'd0;
      r_seq   <= 4'd0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s1    <= {attack, right, left};
      r_s2    <= r_s1;
      r_cnt   <= w_cnt;
      r_sr    <= w_sr;
      r_idx   <= w_idx;
      r_gap   <= w_gap;
      r_seq   <= w_seq;
      r_tx    <= w_tx;
      r_busy  <= w_busy;
    end
  end
  assign tx      = r_tx;
  assign tx_busy = r_busy;
  assign seq     = r_seq;
endmodule

// File: tb/tb_pad_link_tx.sv
// tb_pad_link_tx: directed sequence with randomized payloads, checked against a
// frame-level model (2-clock input delay, 10-bit frame built from payload and seq).
module tb_pad_link_tx;
  localparam int CD = 4;
  localparam int GB = 2;
  logic       clk = 1'b0, rst_n = 1'b0, left = 1'b0, right = 1'b0, attack = 1'b0, send_en = 1'b0;
  logic       tx, tx_busy;
  logic [3:0] seq;
  logic [3:0] m_seq = 4'd0;
  logic [2:0] hist [0:8191];
  logic [9:0] rx;
  int         vecs = 0, fails = 0, cyc = 0, p = 0, pp = 0, w = 0, fw = 0;

  pad_link_tx #(.CLK_DIV(CD), .GAP_BITS(GB)) dut (
    .clk(clk), .rst_n(rst_n), .left(left), .right(right), .attack(attack),
    .send_en(send_en), .tx(tx), .tx_busy(tx_busy), .seq(seq)
  );

  always #5 clk = ~clk;

  // inputs as seen by the synchroniser at each rising edge; reset clears it
  always @(posedge clk) begin
    hist[cyc % 8192] = rst_n ? {attack, right, left} : 3'b000;
    cyc++;
  end

  function automatic logic [9:0] frame_bits(input logic [2:0] pl, input logic [3:0] s);
    logic [6:0] d;
    d = {s, pl};
    frame_bits[0] = 1'b0;
    for (int i = 0; i < 7; i++) frame_bits[i + 1] = d[i];
    frame_bits[8] = ^d;
    frame_bits[9] = 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic frame(input string tag, output int st, output logic [9:0] bits);
    logic [9:0] f;
    int t;
    t = 0;
    bits = '1;
    while (tx !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_start"}, {9'd0, tx}, 10'd0);
    st = cyc - 1;
    f = frame_bits(hist[(st - 2) % 8192], m_seq);
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < CD; j++) begin
        if (b != 0 || j != 0) @(negedge clk);
        if (j == 0) bits[b] = tx;
        chk({tag, "_tx"}, {9'd0, tx}, {9'd0, f[b]});
        chk({tag, "_busy"}, {9'd0, tx_busy}, 10'd1);
        chk({tag, "_seq"}, {6'd0, seq}, {6'd0, m_seq});
      end
    m_seq++;
    chk({tag, "_parity"}, {9'd0, ^bits[8:1]}, 10'd0);
    for (int g = 0; g < GB * CD; g++) begin
      @(negedge clk);
      chk({tag, "_gap_tx"}, {9'd0, tx}, 10'd1);
      chk({tag, "_gap_busy"}, {9'd0, tx_busy}, 10'd1);
      chk({tag, "_gap_seq"}, {6'd0, seq}, {6'd0, m_seq});
    end
    @(negedge clk);
    chk({tag, "_dwell_busy"}, {9'd0, tx_busy}, 10'd0);
    chk({tag, "_dwell_tx"}, {9'd0, tx}, 10'd1);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_tx"}, {9'd0, tx}, 10'd1);
      chk({tag, "_busy"}, {9'd0, tx_busy}, 10'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_seq = 4'd0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("rst_tx", {9'd0, tx}, 10'd1);
      chk("rst_busy", {9'd0, tx_busy}, 10'd0);
      chk("rst_seq", {6'd0, seq}, 10'd0);
    end

    left = 1'b1; right = 1'b0; attack = 1'b1;
    repeat (4) @(negedge clk);
    send_en = 1'b1;
    @(negedge clk);
    send_en = 1'b0;
    frame("single", p, rx);
    chk("single_bits", rx, 10'b1000001010);
    quiet("single_after", 20);
    chk("single_seq", {6'd0, seq}, 10'd1);

    do_reset();
    send_en = 1'b1;
    for (int k = 0; k < 17; k++) begin
      {attack, right, left} = 3'($urandom);
      frame("b2b", p, rx);
      if (k > 0) chk("b2b_period", 10'(p - pp), 10'd49);
      pp = p;
    end
    send_en = 1'b0;
    quiet("b2b_after", 10);
    chk("b2b_seq_wrap", {6'd0, seq}, 10'd1);

    send_en = 1'b1;
    fork
      repeat (34) begin
        repeat (3) @(negedge clk);
        attack = ~attack;
      end
    join_none
    frame("freeze1", p, rx);
    frame("freeze2", p, rx);
    send_en = 1'b0;
    quiet("freeze_after", 10);

    {attack, right, left} = 3'($urandom);
    repeat (5) @(negedge clk);
    send_en = 1'b1;
    fork
      begin
        fw = 0;
        while (tx !== 1'b0 && fw < 300) begin
          @(negedge clk);
          fw++;
        end
        repeat (4 * CD + 1) @(negedge clk);
        send_en = 1'b0;
      end
    join_none
    frame("drop", p, rx);
    quiet("drop_after", 60);

    {attack, right, left} = 3'($urandom);
    if (^{m_seq, attack, right, left}) left = ~left;
    repeat (4) @(negedge clk);
    send_en = 1'b1;
    w = 0;
    while (tx !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("arst_start", {9'd0, tx}, 10'd0);
    repeat (8 * CD + 1) @(negedge clk);
    chk("arst_parity_bit", {9'd0, tx}, 10'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx", {9'd0, tx}, 10'd1);
    chk("arst_busy", {9'd0, tx_busy}, 10'd0);
    chk("arst_seq", {6'd0, seq}, 10'd0);
    repeat (3) @(negedge clk);
    chk("arst_hold_tx", {9'd0, tx}, 10'd1);
    rst_n = 1'b1;
    m_seq = 4'd0;
    frame("post_rst", p, rx);
    send_en = 1'b0;
    quiet("post_rst_after", 10);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
